rx_block_loader: RTL and testbench
==================================

# rx_block_loader

Upstream stage of the RS-232 AES path: takes bytes from the UART receiver, packs them into 32-bit words, and writes them into the 128x32 block RAM. The RAM encrypts each 128-bit block in place. For each block the loader writes four plaintext words, then issues the write that starts AES. It then holds off new input until the RAM has finished writing back the ciphertext.

## Interface

Parameters:
- AES_WAIT, 16: cycles of rx_ready low after the trigger write (covers AES latency plus write-back).
- MAX_BLOCKS, 12: number of 10-word block slots in RAM (highest slot ends at address 10*MAX_BLOCKS; 12 keeps this ≤ 127).
- TIMEOUT_CYC, 100000: inter-byte gap limit; used only when LOADER_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- rx_ready  out  1  high when a byte can be accepted.
- ram_data  out  32  RAM write data.
- ram_addr  out  7  RAM address.
- ram_en  out  1  one-cycle RAM enable.
- ram_action  out  1  1 = write; always 1 whenever ram_en is 1.
- blk_done  out  1  one-cycle pulse on the cycle the trigger write is issued.
- blk_count  out  4  number of completed blocks (0..MAX_BLOCKS).
- full  out  1  high once all MAX_BLOCKS slots are used.
- overrun  out  1  sticky; set when rx_valid arrives while rx_ready is 0.

## Operation

- Block slot k (k = 0..MAX_BLOCKS-1) uses fixed RAM addresses:
  - plaintext words at 10k+1 .. 10k+4;
  - trigger write at 10k+5, data 32'h0;
  - the RAM places ciphertext at 10k+6 .. 10k+9 and the marker 32'hffffffff at 10k+10.
- Byte packing is big-endian:
  - first byte goes to [31:24], fourth byte to [7:0];
  - the first received word goes to the lowest address (10k+1).
- State machine:
  - COLLECT: rx_ready = 1. Accepts bytes. On the 4th byte of a word, go to WRITE.
  - WRITE: one cycle. ram_en = 1, ram_addr = 10k+w, where w (1..4) is the word index.
    - If w < 4: increment w and return to COLLECT.
    - If w = 4: go to TRIGGER.
  - TRIGGER: one cycle. ram_en = 1, ram_addr = 10k+5, ram_data = 0, blk_done = 1. blk_count increments. Go to WAIT.
  - WAIT: hold for AES_WAIT cycles.
    - Then, if blk_count == MAX_BLOCKS, go to FULL.
    - Otherwise set k = k+1, w = 1, and go to COLLECT.
  - FULL: rx_ready = 0 and full = 1 until rst. There is no wrap-around.
- A byte dropped in any state other than COLLECT sets overrun. The dropped byte does not disturb the packer.
- Reset values: state COLLECT, k = 0, w = 1, byte counter 0. All outputs are 0 except rx_ready = 1.
- rst asserted mid-word or mid-block discards any partial data. No RAM write is issued for it.
- When rst and rx_valid are high in the same cycle, rst wins and the byte is dropped.

## Timing

- A 4th byte accepted at cycle t gives a word write at t+1.
  - For word 4, the trigger follows at t+2 and rx_ready returns at t+3+AES_WAIT.
- rx_ready is combinational from state only. It is 0 in WRITE, TRIGGER, WAIT and FULL.
- ram_data and ram_addr are registered. They hold their last value when ram_en is 0.
- blk_done and blk_count update in the TRIGGER cycle.

## Configuration

- LOADER_TIMEOUT_EN defined:
  - A counter runs while in COLLECT with a partial word or block buffered (byte counter ≠ 0 or w ≠ 1). It resets on each accepted byte.
  - When it reaches TIMEOUT_CYC, the byte counter resets to 0 and w resets to 1. k is unchanged, so the slot is reused.
- LOADER_TIMEOUT_EN undefined:
  - No counter is built, and a partial block waits indefinitely.
  - TIMEOUT_CYC is ignored.

## Test plan

- Block written to slot 0:
  - Stimulus: after reset, send 16 bytes 00..0F.
  - Required: writes 1:00010203, 2:04050607, 3:08090A0B, 4:0C0D0E0F, then 5:00000000 with blk_done pulse, blk_count = 1, rx_ready low for AES_WAIT cycles.
- Second block addressing: send 32 bytes. Required: second block writes to addresses 11..14, trigger at 15, blk_count = 2.
- FULL behaviour:
  - Stimulus: send 12 blocks.
  - Required: last trigger at address 115, full = 1, rx_ready = 0.
  - A further rx_valid sets overrun and produces no ram_en.
- Overrun during WAIT: pulse rx_valid during WAIT. Required: overrun = 1, the next block still starts at byte 0.
- Reset mid-block:
  - Stimulus: send 6 bytes, assert rst for 1 cycle, then send 16 bytes AA..B9.
  - Required: first write is 1:AAABACAD, blk_count = 1 afterwards.
- Timeout (LOADER_TIMEOUT_EN, TIMEOUT_CYC = 50):
  - Stimulus: send 3 bytes, idle 60 cycles, send 16 bytes.
  - Required: block packs from the new bytes only and lands at addresses 1..5.

Source files
------------

// File: rtl/rx_block_loader.sv
// rx_block_loader: packs UART bytes into big-endian 32-bit words and writes
// them into the AES block RAM, one 10-word slot per 128-bit block.
// Each block is four plaintext writes followed by a trigger write of zero.
// After the trigger, input is held off while the RAM writes back the
// ciphertext.
// Optional feature: define LOADER_TIMEOUT_EN to discard a partial word or
// block after TIMEOUT_CYC idle cycles.
module rx_block_loader #(
    parameter int AES_WAIT    = 16,
    parameter int MAX_BLOCKS  = 12,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] ram_data,
    output logic [6:0]  ram_addr,
    output logic        ram_en,
    output logic        ram_action,
    output logic        blk_done,
    output logic [3:0]  blk_count,
    output logic        full,
    output logic        overrun
);

    localparam int WAIT_W = (AES_WAIT > 1) ? $clog2(AES_WAIT) : 1;

    // Reject parameter sets whose slots would not fit the 7-bit address space.
    if ((10 * MAX_BLOCKS > 127) || (MAX_BLOCKS > 15) || (MAX_BLOCKS < 1) ||
        (AES_WAIT < 1) || (TIMEOUT_CYC < 2)) begin : g_param_check
        $error("rx_block_loader: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        S_COLLECT,
        S_WRITE,
        S_TRIGGER,
        S_WAIT,
        S_FULL
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [2:0]          word_q, word_d;
    logic [6:0]          base_q, base_d;
    logic [23:0]         pack_q, pack_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [31:0]         ram_data_q, ram_data_d;
    logic [6:0]          ram_addr_q, ram_addr_d;
    logic                ram_en_q, ram_en_d;
    logic                blk_done_q, blk_done_d;
    logic [3:0]          blk_count_q, blk_count_d;
    logic                overrun_q, overrun_d;
    logic                accept;
    logic                timeout_hit;

    // Ready and full depend on state alone so upstream sees no input->output path.
    assign rx_ready   = (state_q == S_COLLECT);
    assign full       = (state_q == S_FULL);
    assign accept     = rx_valid && rx_ready;

    assign ram_data   = ram_data_q;
    assign ram_addr   = ram_addr_q;
    assign ram_en     = ram_en_q;
    assign ram_action = ram_en_q;
    assign blk_done   = blk_done_q;
    assign blk_count  = blk_count_q;
    assign overrun    = overrun_q;

`ifdef LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            partial;

    // Idle-gap counter: runs only while a partial word/block is buffered.
    always_comb begin
        to_cnt_d    = to_cnt_q;
        timeout_hit = 1'b0;
        partial     = (state_q == S_COLLECT) && ((byte_cnt_q != 2'd0) || (word_q != 3'd1));
        if (!partial || accept) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            to_cnt_d    = '0;
            timeout_hit = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Idle-gap counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state, packer and RAM command logic.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        base_d      = base_q;
        pack_d      = pack_q;
        wait_cnt_d  = wait_cnt_q;
        ram_data_d  = ram_data_q;
        ram_addr_d  = ram_addr_q;
        ram_en_d    = 1'b0;
        blk_done_d  = 1'b0;
        blk_count_d = blk_count_q;
        // A byte offered while not ready is lost; remember that it happened.
        overrun_d   = overrun_q | (rx_valid & ~rx_ready);

        case (state_q)
            S_COLLECT: begin
                if (accept) begin
                    if (byte_cnt_q == 2'd3) begin
                        // Word complete: command is registered so it appears in WRITE.
                        ram_en_d   = 1'b1;
                        ram_addr_d = base_q + {4'd0, word_q};
                        ram_data_d = {pack_q, rx_data};
                        byte_cnt_d = 2'd0;
                        state_d    = S_WRITE;
                    end else begin
                        pack_d     = {pack_q[15:0], rx_data};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end else if (timeout_hit) begin
                    // Drop the stale partial data; the slot is reused.
                    byte_cnt_d = 2'd0;
                    word_d     = 3'd1;
                end
            end
            S_WRITE: begin
                if (word_q == 3'd4) begin
                    // Trigger write of zero starts AES on the block.
                    ram_en_d    = 1'b1;
                    ram_addr_d  = base_q + 7'd5;
                    ram_data_d  = 32'h0;
                    blk_done_d  = 1'b1;
                    blk_count_d = blk_count_q + 4'd1;
                    state_d     = S_TRIGGER;
                end else begin
                    word_d  = word_q + 3'd1;
                    state_d = S_COLLECT;
                end
            end
            S_TRIGGER: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_W'(AES_WAIT - 1)) begin
                    if (blk_count_q == 4'(MAX_BLOCKS)) begin
                        state_d = S_FULL;
                    end else begin
                        base_d  = base_q + 7'd10;
                        word_d  = 3'd1;
                        state_d = S_COLLECT;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_FULL: begin
                state_d = S_FULL;
            end
            default: begin
                state_d = S_COLLECT;
            end
        endcase
    end

    // Control and output registers; reset discards any partial word or block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_COLLECT;
            byte_cnt_q  <= 2'd0;
            word_q      <= 3'd1;
            base_q      <= 7'd0;
            wait_cnt_q  <= '0;
            ram_data_q  <= 32'h0;
            ram_addr_q  <= 7'd0;
            ram_en_q    <= 1'b0;
            blk_done_q  <= 1'b0;
            blk_count_q <= 4'd0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            base_q      <= base_d;
            wait_cnt_q  <= wait_cnt_d;
            ram_data_q  <= ram_data_d;
            ram_addr_q  <= ram_addr_d;
            ram_en_q    <= ram_en_d;
            blk_done_q  <= blk_done_d;
            blk_count_q <= blk_count_d;
            overrun_q   <= overrun_d;
        end
    end

    // Byte packer holds data only; validity is tracked by byte_cnt.
    always_ff @(posedge clk) begin
        pack_q <= pack_d;
    end

endmodule

// File: tb/tb_rx_block_loader.sv
// Self-checking bench for rx_block_loader: expected RAM writes go into a
// queue as stimulus is driven and are compared when ram_en fires.
module tb_rx_block_loader;

    localparam int AES_WAIT   = 16;
    localparam int MAX_BLOCKS = 12;
`ifdef LOADER_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 50;
`else
    localparam int TIMEOUT_CYC = 100000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] ram_data;
    logic [6:0]  ram_addr;
    logic        ram_en;
    logic        ram_action;
    logic        blk_done;
    logic [3:0]  blk_count;
    logic        full;
    logic        overrun;

    rx_block_loader #(
        .AES_WAIT    (AES_WAIT),
        .MAX_BLOCKS  (MAX_BLOCKS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .ram_data   (ram_data),
        .ram_addr   (ram_addr),
        .ram_en     (ram_en),
        .ram_action (ram_action),
        .blk_done   (blk_done),
        .blk_count  (blk_count),
        .full       (full),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
        logic        done;
    } wr_t;

    typedef struct {
        logic [31:0] bytes;
        logic [6:0]  addr;
        logic [31:0] data;
    } vec_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Scoreboard: every RAM write must match the oldest expectation.
    always @(negedge clk) begin
        if (ram_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got %h:%h expected none", ram_addr, ram_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {25'd0, ram_addr}, {25'd0, e.addr});
                check("wr_data", ram_data, e.data);
                check("wr_done", {31'd0, blk_done}, {31'd0, e.done});
                check("wr_action", {31'd0, ram_action}, 32'd1);
            end
        end else if (blk_done) begin
            n_checks++;
            $display("FAIL stray_blk_done: got 1 expected 0");
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            fail_now("ready_wait");
            return;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_block(input int k, input logic [7:0] start);
        logic [7:0] b;
        for (int w = 1; w <= 4; w++) begin
            logic [31:0] d;
            for (int i = 0; i < 4; i++) begin
                b = start + 8'(4 * (w - 1) + i);
                d = {d[23:0], b};
            end
            exp_q.push_back({7'(10 * k + w), d, 1'b0});
        end
        exp_q.push_back({7'(10 * k + 5), 32'h0, 1'b1});
        for (int i = 0; i < 16; i++) send_byte(start + 8'(i));
    endtask

    task automatic measure_low(output int n);
        n = 0;
        while (!rx_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl[4];
    int   low;

    initial begin
        tbl[0] = '{32'h00010203, 7'd1, 32'h00010203};
        tbl[1] = '{32'h04050607, 7'd2, 32'h04050607};
        tbl[2] = '{32'h08090A0B, 7'd3, 32'h08090A0B};
        tbl[3] = '{32'h0C0D0E0F, 7'd4, 32'h0C0D0E0F};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_en", {31'd0, ram_en}, 32'd0);
        check("rst_data", ram_data, 32'h0);
        check("rst_addr", {25'd0, ram_addr}, 32'd0);
        check("rst_done", {31'd0, blk_done}, 32'd0);
        check("rst_count", {28'd0, blk_count}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);

        // Block 0 from the vector table
        foreach (tbl[i]) exp_q.push_back({tbl[i].addr, tbl[i].data, 1'b0});
        exp_q.push_back({7'd5, 32'h0, 1'b1});
        for (int i = 0; i < 4; i++) begin
            logic [31:0] v;
            v = tbl[i].bytes;
            for (int j = 3; j >= 0; j--) send_byte(v[8*j +: 8]);
        end
        measure_low(low);
        check("blk0_low_cycles", low, AES_WAIT + 2);
        check("blk0_count", {28'd0, blk_count}, 32'd1);
        check("blk0_addr_hold", {25'd0, ram_addr}, 32'd5);

        // Block 1 lands in slot 1
        send_block(1, 8'h10);
        measure_low(low);
        check("blk1_count", {28'd0, blk_count}, 32'd2);

        // Overrun during WAIT, then next block starts clean
        send_block(2, 8'h20);
        repeat (4) @(negedge clk);
        check("wait_ready_low", {31'd0, rx_ready}, 32'd0);
        rx_data  = 8'hEE;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("wait_overrun", {31'd0, overrun}, 32'd1);
        send_block(3, 8'h30);
        measure_low(low);
        check("blk3_count", {28'd0, blk_count}, 32'd4);
        check("queue_empty_a", exp_q.size(), 0);

        // Reset mid-block, with a byte offered during reset
        do_reset();
        exp_q.push_back({7'd1, 32'h10111213, 1'b0});
        for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i));
        rst      = 1'b1;
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b0;
        check("midrst_overrun", {31'd0, overrun}, 32'd0);
        check("midrst_count", {28'd0, blk_count}, 32'd0);
        exp_q.push_back({7'd1, 32'hAAABACAD, 1'b0});
        exp_q.push_back({7'd2, 32'hAEAFB0B1, 1'b0});
        exp_q.push_back({7'd3, 32'hB2B3B4B5, 1'b0});
        exp_q.push_back({7'd4, 32'hB6B7B8B9, 1'b0});
        exp_q.push_back({7'd5, 32'h00000000, 1'b1});
        for (int i = 0; i < 16; i++) send_byte(8'hAA + 8'(i));
        measure_low(low);
        check("midrst_blk_count", {28'd0, blk_count}, 32'd1);

`ifdef LOADER_TIMEOUT_EN
        // Partial word abandoned after the idle gap
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(8'hF0 + 8'(i));
        repeat (60) @(negedge clk);
        send_block(0, 8'h40);
        measure_low(low);
        check("timeout_count", {28'd0, blk_count}, 32'd1);
`endif

        // Fill every slot
        do_reset();
        for (int k = 0; k < MAX_BLOCKS; k++) send_block(k, 8'(16 * k));
        low = 0;
        while (!full && low < 200) begin
            low++;
            @(negedge clk);
        end
        if (!full) fail_now("full_wait");
        check("full_flag", {31'd0, full}, 32'd1);
        check("full_ready", {31'd0, rx_ready}, 32'd0);
        check("full_count", {28'd0, blk_count}, MAX_BLOCKS);
        check("full_overrun_clear", {31'd0, overrun}, 32'd0);
        check("full_last_addr", {25'd0, ram_addr}, 32'd115);
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("full_overrun", {31'd0, overrun}, 32'd1);
        check("full_stays", {31'd0, full}, 32'd1);
        check("queue_empty_end", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
